// File: rtl/mux_pkg.sv
// Shared constants for the N-to-1 pipelined channel multiplexer:
// mode encodings, output-stage state encodings and default parameters.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam int N_CH_DEFAULT = 8;
    localparam int DW_DEFAULT   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request search: returns the first requesting channel found
// when scanning upward from i_ptr, wrapping modulo N_CH.
module rr_arbiter #(
    parameter int N_CH = 8,
    parameter int SELW = $clog2(N_CH)
)(
    input  logic [N_CH-1:0] i_req,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_grant,
    output logic            o_grant_vld
);

    logic [SELW-1:0] w_idx;

    // Scan from the farthest offset down to offset zero so the closest hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_vld = 1'b0;
        w_idx       = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            w_idx = SELW'((32'(i_ptr) + 32'(i)) % 32'(N_CH));
            if (i_req[w_idx]) begin
                o_grant     = w_idx;
                o_grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// N-to-1 channel multiplexer with a single registered output entry.
// Fixed-select or round-robin channel choice, full-throughput handshake.
// Optional even-parity output enabled by defining MUX_NX1_PIPE_PARITY_EN.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT,
    parameter int DW   = DW_DEFAULT,
    parameter int SELW = $clog2(N_CH)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH*DW-1:0] in_data,
    input  logic [N_CH-1:0]    in_valid,
    output logic [N_CH-1:0]    in_ready,
    input  logic [SELW-1:0]    sel,
    input  logic               mode,
    output logic [DW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_ch
`ifdef MUX_NX1_PIPE_PARITY_EN
    ,
    output logic               out_par
`endif
);

    logic [DW-1:0]   w_chData [N_CH];
    logic [SELW-1:0] w_rrGrant;
    logic            w_rrVld;
    logic            w_selInRange;
    logic            w_fixedVld;
    logic [SELW-1:0] w_grant;
    logic            w_grantVld;
    logic            w_loadOk;
    logic            w_accept;
    logic [SELW-1:0] w_nextPtr;

    logic [0:0]      r_state;
    logic [DW-1:0]   r_outData;
    logic [SELW-1:0] r_outCh;
    logic [SELW-1:0] r_rrPtr;
`ifdef MUX_NX1_PIPE_PARITY_EN
    logic            r_outPar;
`endif

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_unpack
            assign w_chData[k] = in_data[k*DW +: DW];
        end
    endgenerate

    rr_arbiter #(
        .N_CH (N_CH),
        .SELW (SELW)
    ) u_rr_arbiter (
        .i_req       (in_valid),
        .i_ptr       (r_rrPtr),
        .o_grant     (w_rrGrant),
        .o_grant_vld (w_rrVld)
    );

    // An out-of-range select must grant nothing, so range is tested before use.
    assign w_selInRange = (32'(sel) < 32'(N_CH));
    assign w_fixedVld   = w_selInRange && in_valid[sel];

    assign w_grant    = (mode == MODE_RR) ? w_rrGrant : sel;
    assign w_grantVld = (mode == MODE_RR) ? w_rrVld   : w_fixedVld;

    assign w_loadOk  = (r_state == ST_EMPTY) || out_ready;
    assign w_accept  = w_grantVld && w_loadOk && !rst;
    assign w_nextPtr = (32'(w_grant) == 32'(N_CH - 1)) ? '0 : w_grant + 1'b1;

    // Only the granted channel ever sees ready, and never while in reset.
    always_comb begin
        in_ready = '0;
        if (w_accept) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    // Output entry: load on accept, drop on drain without accept, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_outData <= '0;
            r_outCh   <= '0;
            r_rrPtr   <= '0;
`ifdef MUX_NX1_PIPE_PARITY_EN
            r_outPar  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_state   <= ST_FULL;
            r_outData <= w_chData[w_grant];
            r_outCh   <= w_grant;
`ifdef MUX_NX1_PIPE_PARITY_EN
            r_outPar  <= ^w_chData[w_grant];
`endif
            if (mode == MODE_RR) begin
                r_rrPtr <= w_nextPtr;
            end
        end else if ((r_state == ST_FULL) && out_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_outData;
    assign out_ch    = r_outCh;
`ifdef MUX_NX1_PIPE_PARITY_EN
    assign out_par   = r_outPar;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: a vector table for single-beat behaviour
// plus hand-written stall, round-robin wrap and reset sequences.
// A second instance with six channels exercises the out-of-range select.
module tb_mux_nx1_pipe;

    localparam int N_CH = 8;
    localparam int DW   = 8;
    localparam int SELW = 3;
    localparam int N6   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH-1:0]    in_valid;
    logic [N_CH-1:0]    in_ready;
    logic [SELW-1:0]    sel;
    logic               mode;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_ch;

    logic               rst6;
    logic [N6*DW-1:0]   in_data6;
    logic [N6-1:0]      in_valid6;
    logic [N6-1:0]      in_ready6;
    logic [2:0]         sel6;
    logic               mode6;
    logic [DW-1:0]      out_data6;
    logic               out_valid6;
    logic               out_ready6;
    logic [2:0]         out_ch6;

`ifdef MUX_NX1_PIPE_PARITY_EN
    logic out_par;
    logic out_par6;
`endif

    int checks   = 0;
    int failures = 0;

    mux_nx1_pipe #(.N_CH(N_CH), .DW(DW), .SELW(SELW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
`ifdef MUX_NX1_PIPE_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    mux_nx1_pipe #(.N_CH(N6), .DW(DW), .SELW(3)) dut6 (
        .clk       (clk),
        .rst       (rst6),
        .in_data   (in_data6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .sel       (sel6),
        .mode      (mode6),
        .out_data  (out_data6),
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .out_ch    (out_ch6)
`ifdef MUX_NX1_PIPE_PARITY_EN
        ,
        .out_par   (out_par6)
`endif
    );

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] valid;
        logic [7:0] expReady;
        logic       expValid;
        logic [2:0] expCh;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [11];

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive the main instance's control inputs.
    task automatic applyStimulus(input logic m, input logic [2:0] s, input logic [7:0] v, input logic ordy);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
    endtask

    initial begin
        // Channel k carries 8'hA0+k on the main instance and 8'hB0+k on the six-channel one.
        vecs[0]  = '{1'b0, 3'd5, 8'h20, 8'h20, 1'b1, 3'd5, 8'hA5};
        vecs[1]  = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[2]  = '{1'b0, 3'd0, 8'hFF, 8'h01, 1'b1, 3'd0, 8'hA0};
        vecs[3]  = '{1'b0, 3'd7, 8'h80, 8'h80, 1'b1, 3'd7, 8'hA7};
        vecs[4]  = '{1'b0, 3'd3, 8'hF7, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[5]  = '{1'b0, 3'd2, 8'h04, 8'h04, 1'b1, 3'd2, 8'hA2};
        vecs[6]  = '{1'b1, 3'd5, 8'h84, 8'h04, 1'b1, 3'd2, 8'hA2};
        vecs[7]  = '{1'b1, 3'd5, 8'h84, 8'h80, 1'b1, 3'd7, 8'hA7};
        vecs[8]  = '{1'b1, 3'd5, 8'h84, 8'h04, 1'b1, 3'd2, 8'hA2};
        vecs[9]  = '{1'b1, 3'd5, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[10] = '{1'b1, 3'd5, 8'h01, 8'h01, 1'b1, 3'd0, 8'hA0};

        in_data  = {8'hA7, 8'hA6, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_data6 = {8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};

        // Reset with a valid request present: nothing may be accepted.
        rst  = 1'b1;
        rst6 = 1'b1;
        applyStimulus(1'b0, 3'd5, 8'h20, 1'b1);
        mode6 = 1'b0; sel6 = 3'd0; in_valid6 = '0; out_ready6 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  64'(in_ready),  64'h0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'h0);
        checkOutput("rst_out_data",  64'(out_data),  64'h0);
        checkOutput("rst_out_ch",    64'(out_ch),    64'h0);
        checkOutput("rst6_out_valid", 64'(out_valid6), 64'h0);
        @(negedge clk);
        rst  = 1'b0;
        rst6 = 1'b0;

        // Table-driven single beats, downstream always ready.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].valid, 1'b1);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].expReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d_out_ch", i),   64'(out_ch),   64'(vecs[i].expCh));
                checkOutput($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].expData));
`ifdef MUX_NX1_PIPE_PARITY_EN
                checkOutput($sformatf("vec%0d_out_par", i), 64'(out_par), 64'(^vecs[i].expData));
`endif
            end
        end

        // Stall: load ch5, hold for three cycles while ch2 waits, then drain+load together.
        @(negedge clk);
        applyStimulus(1'b0, 3'd5, 8'h20, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("stall_load_ch",   64'(out_ch),   64'd5);
        checkOutput("stall_load_data", 64'(out_data), 64'hA5);
        @(negedge clk);
        applyStimulus(1'b0, 3'd2, 8'h04, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'h0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall%0d_out_valid", c), 64'(out_valid), 64'h1);
            checkOutput($sformatf("stall%0d_out_ch", c),    64'(out_ch),    64'd5);
            checkOutput($sformatf("stall%0d_out_data", c),  64'(out_data),  64'hA5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("release_in_ready", 64'(in_ready), 64'h04);
        @(posedge clk);
        #1;
        checkOutput("release_out_valid", 64'(out_valid), 64'h1);
        checkOutput("release_out_ch",    64'(out_ch),    64'd2);
        checkOutput("release_out_data",  64'(out_data),  64'hA2);
        @(negedge clk);
        in_valid = 8'h00;
        @(posedge clk);
        #1;
        checkOutput("drain_out_valid", 64'(out_valid), 64'h0);

        // Round-robin with every channel requesting: pointer starts at 0 after reset.
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        #1;
        checkOutput("rr_rst_in_ready", 64'(in_ready), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("rr_rst_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rr%0d_out_ch", c),   64'(out_ch),   64'(c % 8));
            checkOutput($sformatf("rr%0d_out_data", c), 64'(out_data), 64'(8'hA0 + 8'(c % 8)));
        end

        // Six-channel instance: select beyond the channel count grants nothing.
        @(negedge clk);
        mode6 = 1'b0; sel6 = 3'd7; in_valid6 = 6'h3F; out_ready6 = 1'b1;
        #1;
        checkOutput("n6_sel7_in_ready", 64'(in_ready6), 64'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("n6_sel7_out_valid", 64'(out_valid6), 64'h0);
        end
        @(negedge clk);
        sel6 = 3'd1;
        #1;
        checkOutput("n6_sel1_in_ready", 64'(in_ready6), 64'h02);
        @(posedge clk);
        #1;
        checkOutput("n6_sel1_out_valid", 64'(out_valid6), 64'h1);
        checkOutput("n6_sel1_out_data",  64'(out_data6),  64'hB1);
        checkOutput("n6_sel1_out_ch",    64'(out_ch6),    64'd1);

        // Reset while the entry is full and stalled discards the beat.
        @(negedge clk);
        out_ready6 = 1'b0;
        rst6 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("n6_rst_full_out_valid", 64'(out_valid6), 64'h0);
        checkOutput("n6_rst_full_out_data",  64'(out_data6),  64'h0);
        @(negedge clk);
        rst6 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 Parameter N_CH, default 8, number of input channels (2..32).
REQ-002 Parameter DW, default 8, data width per channel (1..64).
REQ-003 Parameter SELW, default $clog2(N_CH), select/channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N_CH*DW  channel k occupies bits [k*DW +: DW].
REQ-007 in_valid  input  N_CH  per-channel data-valid.
REQ-008 in_ready  output  N_CH  per-channel accept; at most one bit high per cycle.
REQ-009 sel  input  SELW  channel index used in fixed mode.
REQ-010 mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 out_data  output  DW  registered selected data.
REQ-012 out_valid  output  1  out_data/out_ch hold a beat.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 out_ch  output  SELW  index of the channel that supplied out_data.

Function
REQ-015 Output stage SHALL be one registered entry; a beat transfers downstream when out_valid && out_ready.
REQ-016 Load condition: load_ok = !out_valid || out_ready (full throughput, one beat per cycle).
REQ-017 Fixed mode: grant = sel when sel < N_CH and in_valid[sel]; sel >= N_CH grants nothing.
REQ-018 Round-robin mode: grant = first k with in_valid[k], searching from rr_ptr upward modulo N_CH; none if no valid.
REQ-019 in_ready[grant] = load_ok; all other in_ready bits 0; in_ready is combinational and SHALL NOT depend on in_valid of ungranted channels.
REQ-020 On in_valid[grant] && in_ready[grant]: out_data <= channel data, out_ch <= grant, out_valid <= 1, latency one cycle.
REQ-021 out_valid && out_ready with no grant: out_valid <= 0 next cycle.
REQ-022 out_valid && !out_ready: out_data, out_ch, out_valid SHALL hold unchanged.
REQ-023 rr_ptr <= (grant+1) mod N_CH on each accepted beat in round-robin mode, wrapping N_CH-1 -> 0; unchanged otherwise.
REQ-024 Mode or sel change SHALL affect only the next grant; a held output beat is never altered.
REQ-025 State machine: EMPTY (out_valid=0) -> FULL on accept; FULL -> FULL on simultaneous drain+accept; FULL -> EMPTY on drain without accept; FULL stall holds.

Reset
REQ-026 On rst: out_valid=0, out_data=0, out_ch=0, rr_ptr=0, state EMPTY; in_ready all 0 during rst.
REQ-027 rst asserted mid-transfer SHALL discard the held beat; no beat is accepted in a reset cycle.

Configuration
REQ-028 Macro MUX_NX1_PIPE_PARITY_EN: when defined, adds output out_par (1 bit), even parity of out_data, registered with out_data, reset 0.
REQ-029 Without MUX_NX1_PIPE_PARITY_EN the out_par port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package mux_pkg SHALL hold mode encodings MODE_FIXED=0, MODE_RR=1 and default parameter constants.
REQ-031 Round-robin search SHALL be one sub-module, rr_arbiter (inputs req, ptr; outputs grant index, grant_vld).
REQ-032 All registers in a single clk-edge process; no latches, no internal tristates.

Verification
REQ-033 N_CH=8, DW=8, mode=0, sel=5, in_valid=8'h20, ch5=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=5, out_valid=1.
REQ-034 Stall: out_valid=1, out_ready=0 for 3 cycles -> out_data/out_ch constant, in_ready=0; release -> new beat loaded same cycle as drain.
REQ-035 mode=1, all in_valid=1, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1 (wrap).
REQ-036 mode=1, in_valid=8'b1000_0100, rr_ptr=3 -> grant 7, then rr_ptr=0 -> grant 2.
REQ-037 N_CH=6, mode=0, sel=7 -> in_ready=0, out_valid stays 0; rst during FULL -> out_valid=0 next cycle.
REQ-038 With MUX_NX1_PIPE_PARITY_EN, out_data=8'h07 -> out_par=1; out_data=8'h03 -> out_par=0.
